// File: rtl/seg_scan_if.sv
// Segment-scanner bus: display data going in, segment/anode pins and
// scan strobes coming out.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 8
);
  logic [NUM_DIGITS*DATA_W-1:0] digits_in;
  logic [NUM_DIGITS-1:0]        digit_en;
  logic [DATA_W-1:0]            seg;
  logic [NUM_DIGITS-1:0]        an;
  logic                         slot_tick;
  logic                         frame_tick;

  // Data-register side: supplies patterns and enables, observes the pins.
  modport master (
    output digits_in, digit_en,
    input  seg, an, slot_tick, frame_tick
  );

  // Scanner side.
  modport slave (
    input  digits_in, digit_en,
    output seg, an, slot_tick, frame_tick
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Seven-segment scanner. It time-multiplexes NUM_DIGITS active-low patterns
// onto one segment bus with active-low anodes. Each slot opens with a blank
// interval that suppresses ghosting. Data is captured once per slot on
// entry to SHOW, so mid-slot input changes never tear a digit.
module seg_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int DATA_W       = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  seg_scan_if.slave   bus
);

  localparam int PW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW         = $clog2(NUM_DIGITS);
  localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  localparam logic [PW-1:0] POS_LAST   = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_EXIT = PW'(BLANK_LAST);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                  state, state_d;
  logic [PW-1:0]           pos, pos_d;
  logic [IW-1:0]           idx, idx_d;
  logic                    first;
  logic                    wrap, load, blank;
  logic [DATA_W-1:0]       seg_sel;
  logic                    en_sel;
  logic [NUM_DIGITS-1:0]   an_sel;

  // Next slot position, digit index and state; decides when to capture or blank.
  always_comb begin
    wrap    = (pos == POS_LAST);
    pos_d   = wrap ? '0 : pos + 1'b1;
    idx_d   = idx;
    if (wrap) idx_d = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    state_d = state;
    load    = 1'b0;
    blank   = 1'b0;
    if (BLANK_CYCLES == 0) begin
      // No blank interval: capture on every wrap, plus once right after reset.
      state_d = SHOW;
      load    = wrap || first;
    end else begin
      case (state)
        BLANK: if (pos == BLANK_EXIT) begin
          state_d = SHOW;
          load    = 1'b1;
        end
        SHOW: if (wrap) begin
          state_d = BLANK;
          blank   = 1'b1;
        end
        default: state_d = BLANK;
      endcase
    end
    // The digit to capture is the one whose slot the next cycle belongs to.
    seg_sel = bus.digits_in[idx_d*DATA_W +: DATA_W];
    en_sel  = bus.digit_en[idx_d];
    an_sel  = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d);
  end

  // Scan counters and state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (BLANK_CYCLES == 0) ? SHOW : BLANK;
      pos   <= '0;
      idx   <= '0;
      first <= 1'b1;
    end else begin
      state <= state_d;
      pos   <= pos_d;
      idx   <= idx_d;
      first <= 1'b0;
    end
  end

  // Registered pins and strobes; segments and anodes change only on capture or blank.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.seg        <= '1;
      bus.an         <= '1;
      bus.slot_tick  <= 1'b0;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.slot_tick  <= wrap;
      bus.frame_tick <= wrap && (idx_d == '0);
      if (load) begin
        if (en_sel) begin
          bus.seg <= seg_sel;
          bus.an  <= an_sel;
        end else begin
          bus.seg <= '1;
          bus.an  <= '1;
        end
      end else if (blank) begin
        bus.seg <= '1;
        bus.an  <= '1;
      end
    end
  end

endmodule
